// File: rtl/inst_rom_axi_rd_slave.sv
// AXI4 read-only responder (AR/R) serving instruction fetches from an internal word array.
// Supports INCR/FIXED bursts, whole-burst and per-beat SLVERR, and a backdoor load port.
module inst_rom_axi_rd_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned SPAN_BYTES = DEPTH * 4;
    localparam logic [3:0]  LAT_LAST   = 4'(RD_LATENCY - 1);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [3:0]  lat_cnt;
    logic [3:0]  lat_d;
    logic [7:0]  beat;
    logic [7:0]  beat_d;
    logic        present;

    logic [31:0] start_addr;
    logic [7:0]  len;
    logic        fixed;
    logic        err;

    logic        arready_d;
    logic        rvalid_d;
    logic        rlast_d;
    logic [1:0]  rresp_d;
    logic [31:0] rdata_d;

    logic        ar_hs;
    logic        last_beat;
    logic [31:0] beat_addr;
    logic [31:0] rd_off;
    logic        rd_ok;
    logic [31:0] rd_word;
    logic [31:0] load_off;
    logic        load_ok;

    logic [31:0] mem [DEPTH];

    assign ar_hs     = arvalid && arready;
    assign last_beat = (beat == len);

    // Backdoor load: only aligned, in-range words are written; array is never reset.
    assign load_off = load_addr - BASE_ADDR;
    assign load_ok  = load_en && (load_addr >= BASE_ADDR) &&
                      (load_off < 32'(SPAN_BYTES)) && (load_addr[1:0] == 2'b00);

    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[load_off[IDX_W+1:2]] <= load_data;
        end
    end

    // Address of the beat about to be presented; the read is sampled into rdata at the edge.
    assign beat_addr = start_addr + (fixed ? 32'd0 : {22'd0, beat_d, 2'b00});
    assign rd_off    = beat_addr - BASE_ADDR;
    assign rd_ok     = !err && (beat_addr >= BASE_ADDR) && (rd_off < 32'(SPAN_BYTES));
    assign rd_word   = mem[rd_off[IDX_W+1:2]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus latency/beat counters and the "present a new beat" strobe.
    always_comb begin
        state_d = state;
        lat_d   = lat_cnt;
        beat_d  = beat;
        present = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d = ST_WAIT;
                    lat_d   = 4'd0;
                    beat_d  = 8'd0;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_d = ST_BEAT;
                    beat_d  = 8'd0;
                    present = 1'b1;
                end else begin
                    lat_d = lat_cnt + 4'd1;
                end
            end
            ST_BEAT: begin
                if (rready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat + 8'd1;
                        present = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered AXI outputs; held while stalled.
    always_comb begin
        arready_d = arready;
        rvalid_d  = rvalid;
        rlast_d   = rlast;
        rresp_d   = rresp;
        rdata_d   = rdata;
        unique case (state)
            ST_IDLE: begin
                arready_d = !ar_hs;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
            ST_WAIT: begin
                arready_d = 1'b0;
            end
            ST_BEAT: begin
                if (rready && last_beat) begin
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    rresp_d   = RESP_OKAY;
                    rdata_d   = 32'd0;
                end
            end
            default: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
        if (present) begin
            rvalid_d = 1'b1;
            rlast_d  = (beat_d == len);
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_ok ? rd_word : 32'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arready    <= 1'b1;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rresp      <= RESP_OKAY;
            rdata      <= 32'd0;
            lat_cnt    <= 4'd0;
            beat       <= 8'd0;
            start_addr <= 32'd0;
            len        <= 8'd0;
            fixed      <= 1'b0;
            err        <= 1'b0;
        end else begin
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rresp   <= rresp_d;
            rdata   <= rdata_d;
            lat_cnt <= lat_d;
            beat    <= beat_d;
            if (ar_hs) begin
                start_addr <= araddr;
                len        <= arlen;
                fixed      <= (arburst == BURST_FIXED);
                err        <= (araddr[1:0] != 2'b00) || (arsize != 3'b010) || arburst[1];
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_axi_rd_slave.sv
// Directed self-checking bench for inst_rom_axi_rd_slave.
module tb_inst_rom_axi_rd_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] LAST_WORD = 32'h8000_3FFC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = 32'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [31:0] load_data = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] got_data [256];
    logic [1:0]  got_resp [256];
    logic        got_last [256];
    int          got_n;
    bit          got_to;
    bit          got_stable;

    inst_rom_axi_rd_slave dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial forever #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic [2:0] s);
        araddr = a; arlen = l; arburst = b; arsize = s; arvalid = 1'b1;
        tick();
        arvalid = 1'b0; arsize = 3'b010; arburst = 2'b01;
    endtask

    // Gathers beats of one burst; optionally stalls a chosen beat and records its stability.
    task automatic collect(input int max_beats, input int stall_beat, input int stall_cyc);
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        int          idle;
        bit          done;
        got_n = 0; got_to = 0; got_stable = 1; idle = 0; done = 0;
        rready = 1'b1;
        while (!done) begin
            if (rvalid === 1'b1) begin
                if (got_n == stall_beat && stall_cyc > 0) begin
                    rready = 1'b0;
                    d = rdata; r = rresp; l = rlast;
                    repeat (stall_cyc) begin
                        tick();
                        if (rvalid !== 1'b1 || rdata !== d || rresp !== r || rlast !== l)
                            got_stable = 0;
                    end
                    rready = 1'b1;
                end
                got_data[got_n] = rdata; got_resp[got_n] = rresp; got_last[got_n] = rlast;
                l = rlast;
                got_n++;
                tick();
                if (l === 1'b1 || got_n >= max_beats) done = 1;
            end else begin
                tick();
                idle++;
                if (idle > 50) begin got_to = 1; done = 1; end
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL reset_arready got %0b want 1", arready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (rlast !== 1'b0) begin n_bad++; $display("FAIL reset_rlast got %0b want 0", rlast); end
        n_cmp++; if (rresp !== 2'b00) begin n_bad++; $display("FAIL reset_rresp got %0b want 00", rresp); end
        n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %0h want 0", rdata); end
    endtask

    task automatic test_single();
        rready = 1'b1;
        issue_ar(BASE + 32'd4, 8'd0, 2'b01, 3'b010);
        n_cmp++; if (arready !== 1'b0) begin n_bad++; $display("FAIL single_arready_drop got %0b want 0", arready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL single_rvalid_c0 got %0b want 0", rvalid); end
        tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL single_rvalid_c1 got %0b want 0", rvalid); end
        tick();
        n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL single_rvalid_c2 got %0b want 1", rvalid); end
        n_cmp++; if (rdata !== 32'd22) begin n_bad++; $display("FAIL single_rdata got %0d want 22", rdata); end
        n_cmp++; if (rresp !== 2'b00) begin n_bad++; $display("FAIL single_rresp got %0b want 00", rresp); end
        n_cmp++; if (rlast !== 1'b1) begin n_bad++; $display("FAIL single_rlast got %0b want 1", rlast); end
        tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL single_rvalid_end got %0b want 0", rvalid); end
        n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL single_arready_end got %0b want 1", arready); end
        rready = 1'b0;
    endtask

    task automatic test_incr_stall();
        issue_ar(BASE, 8'd3, 2'b01, 3'b010);
        collect(256, 1, 3);
        n_cmp++; if (got_to !== 1'b0) begin n_bad++; $display("FAIL incr_timeout got %0b want 0", got_to); end
        n_cmp++; if (got_n != 4) begin n_bad++; $display("FAIL incr_count got %0d want 4", got_n); end
        n_cmp++; if (got_stable !== 1'b1) begin n_bad++; $display("FAIL incr_stall_stable got %0b want 1", got_stable); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got_data[i] !== 32'(11 * (i + 1))) begin n_bad++; $display("FAIL incr_data[%0d] got %0d want %0d", i, got_data[i], 11 * (i + 1)); end
            n_cmp++; if (got_resp[i] !== 2'b00) begin n_bad++; $display("FAIL incr_resp[%0d] got %0b want 00", i, got_resp[i]); end
            n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL incr_last[%0d] got %0b want %0b", i, got_last[i], i == 3); end
        end
    endtask

    task automatic test_fixed();
        issue_ar(BASE + 32'd8, 8'd2, 2'b00, 3'b010);
        collect(256, -1, 0);
        n_cmp++; if (got_n != 3) begin n_bad++; $display("FAIL fixed_count got %0d want 3", got_n); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_data[i] !== 32'd33) begin n_bad++; $display("FAIL fixed_data[%0d] got %0d want 33", i, got_data[i]); end
            n_cmp++; if (got_last[i] !== (i == 2)) begin n_bad++; $display("FAIL fixed_last[%0d] got %0b want %0b", i, got_last[i], i == 2); end
        end
    endtask

    task automatic test_boundary();
        issue_ar(LAST_WORD, 8'd1, 2'b01, 3'b010);
        collect(256, -1, 0);
        n_cmp++; if (got_n != 2) begin n_bad++; $display("FAIL bound_count got %0d want 2", got_n); end
        n_cmp++; if (got_data[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bound_data0 got %0h want deadbeef", got_data[0]); end
        n_cmp++; if (got_resp[0] !== 2'b00) begin n_bad++; $display("FAIL bound_resp0 got %0b want 00", got_resp[0]); end
        n_cmp++; if (got_last[0] !== 1'b0) begin n_bad++; $display("FAIL bound_last0 got %0b want 0", got_last[0]); end
        n_cmp++; if (got_data[1] !== 32'd0) begin n_bad++; $display("FAIL bound_data1 got %0h want 0", got_data[1]); end
        n_cmp++; if (got_resp[1] !== 2'b10) begin n_bad++; $display("FAIL bound_resp1 got %0b want 10", got_resp[1]); end
        n_cmp++; if (got_last[1] !== 1'b1) begin n_bad++; $display("FAIL bound_last1 got %0b want 1", got_last[1]); end
    endtask

    task automatic test_errors();
        logic [31:0] a_v [3] = '{BASE + 32'd2, BASE, BASE + 32'd4};
        logic [7:0]  l_v [3] = '{8'd1, 8'd0, 8'd0};
        logic [1:0]  b_v [3] = '{2'b01, 2'b10, 2'b01};
        logic [2:0]  s_v [3] = '{3'b010, 3'b010, 3'b001};
        for (int t = 0; t < 3; t++) begin
            issue_ar(a_v[t], l_v[t], b_v[t], s_v[t]);
            collect(256, -1, 0);
            n_cmp++; if (got_n != int'(l_v[t]) + 1) begin n_bad++; $display("FAIL err%0d_count got %0d want %0d", t, got_n, int'(l_v[t]) + 1); end
            for (int i = 0; i <= int'(l_v[t]); i++) begin
                n_cmp++; if (got_resp[i] !== 2'b10) begin n_bad++; $display("FAIL err%0d_resp[%0d] got %0b want 10", t, i, got_resp[i]); end
                n_cmp++; if (got_data[i] !== 32'd0) begin n_bad++; $display("FAIL err%0d_data[%0d] got %0h want 0", t, i, got_data[i]); end
                n_cmp++; if (got_last[i] !== (i == int'(l_v[t]))) begin n_bad++; $display("FAIL err%0d_last[%0d] got %0b", t, i, got_last[i]); end
            end
        end
    endtask

    task automatic test_long_burst();
        issue_ar(BASE, 8'd255, 2'b01, 3'b010);
        collect(256, -1, 0);
        n_cmp++; if (got_n != 256) begin n_bad++; $display("FAIL long_count got %0d want 256", got_n); end
        n_cmp++; if (got_last[254] !== 1'b0) begin n_bad++; $display("FAIL long_last254 got %0b want 0", got_last[254]); end
        n_cmp++; if (got_last[255] !== 1'b1) begin n_bad++; $display("FAIL long_last255 got %0b want 1", got_last[255]); end
        n_cmp++; if (got_data[3] !== 32'd44) begin n_bad++; $display("FAIL long_data3 got %0d want 44", got_data[3]); end
    endtask

    task automatic test_load_stall();
        int k;
        rready = 1'b0;
        issue_ar(BASE + 32'd8, 8'd0, 2'b01, 3'b010);
        k = 0;
        while (rvalid !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL ld_rvalid got %0b want 1", rvalid); end
        load_word(BASE + 32'd8, 32'h55);
        n_cmp++; if (rdata !== 32'd33) begin n_bad++; $display("FAIL ld_held_rdata got %0h want 21", rdata); end
        rready = 1'b1;
        tick();
        issue_ar(BASE + 32'd8, 8'd0, 2'b01, 3'b010);
        collect(256, -1, 0);
        n_cmp++; if (got_data[0] !== 32'h55) begin n_bad++; $display("FAIL ld_new_rdata got %0h want 55", got_data[0]); end
    endtask

    task automatic test_reset_mid();
        int k;
        rready = 1'b1;
        issue_ar(BASE, 8'd3, 2'b01, 3'b010);
        k = 0;
        while (rvalid !== 1'b1 && k < 20) begin tick(); k++; end
        tick();
        n_cmp++; if (rdata !== 32'd22) begin n_bad++; $display("FAIL rmid_beat1 got %0d want 22", rdata); end
        reset = 1'b1;
        #1;
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL rmid_arready got %0b want 1", arready); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        issue_ar(BASE + 32'd12, 8'd0, 2'b01, 3'b010);
        collect(256, -1, 0);
        n_cmp++; if (got_n != 1) begin n_bad++; $display("FAIL rmid_count got %0d want 1", got_n); end
        n_cmp++; if (got_data[0] !== 32'd44) begin n_bad++; $display("FAIL rmid_data got %0d want 44", got_data[0]); end
        n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_last got %0b want 1", got_last[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        tick();
        reset = 1'b0;
        tick();
        load_word(BASE,          32'd11);
        load_word(BASE + 32'd4,  32'd22);
        load_word(BASE + 32'd8,  32'd33);
        load_word(BASE + 32'd12, 32'd44);
        load_word(LAST_WORD,     32'hDEAD_BEEF);
        load_word(BASE + 32'd1,      32'h99);
        load_word(BASE + 32'h4000,   32'h77);
        test_single();
        test_incr_stall();
        test_fixed();
        test_boundary();
        test_errors();
        test_long_burst();
        test_load_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
